div_seq: RTL and testbench
==========================

# div_seq

Sequential restoring shift-subtract divider: the inverse of the team's combinational shift-add multiplier `mul`. It accepts an n-bit unsigned dividend and divisor on a start pulse. It produces one quotient bit per clock and returns an n-bit quotient and n-bit remainder with a one-cycle done pulse. It sits beside `mul` in the arithmetic datapath and serves multi-cycle divide requests from a controller.

## Interface
- `n`, default 8: operand width; must be ≥ 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  n  unsigned dividend; sampled with accepted `start`.
- `b`  input  n  unsigned divisor; sampled with accepted `start`.
- `q`  output  n  quotient, registered.
- `r`  output  n  remainder, registered.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; `q`, `r` and `dz` are valid from this cycle.
- `dz`  output  1  divide-by-zero flag for the last result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 at an edge accepts the request; latch `a`, `b`.
  - If `b`≠0: clear partial remainder P (n+1 bits), load shift register A←`a`, clear counter, go to RUN.
  - If `b`=0: go directly to DONE with `q`←all ones, `r`←`a`, `dz`←1.
- RUN, one iteration per edge:
  - P'={P[n-1:0],A[n-1]}; A'={A[n-2:0],1'b0}.
  - If P' ≥ {1'b0,B}: P'←P'−B and A'[0]←1.
  - After the n-th iteration: `q`←A', `r`←P'[n-1:0], `dz`←0, go to DONE.
- DONE: `done`=1 for exactly this cycle; unconditionally go to IDLE.
- `start` is ignored in RUN and DONE; it is not queued.
- `start` held high continuously: a new request is accepted at the first IDLE edge after DONE.
- `q`, `r` and `dz` hold their value until the next completed operation overwrites them.
- They do not change during RUN.
- Arithmetic is purely unsigned.
- The subtraction is done at width n+1, so no overflow is possible.
- Invariant: `r` < `b` when `dz`=0.

## Timing
- Reset values: state=IDLE, `q`=0, `r`=0, `busy`=0, `done`=0, `dz`=0, counter=0, internal A/P/B=0.
- Reset asserted mid-RUN or in DONE: the operation is aborted at that edge with no `done` pulse, and all outputs return to reset values.
- Let E0 be the edge that accepts `start`, with `b`≠0:
  - `busy`=1 in the cycles following E0 through E0+n−1.
  - Results are registered at E0+n.
  - `done`=1 in the cycle after E0+n, i.e. latency n+1 cycles from acceptance to `done`.
- `b`=0: `done` is visible in the cycle after E0 (latency 1), and `busy` never asserts.
- Minimum issue interval: n+2 cycles, or 2 cycles for divide-by-zero.
- `start` and `rst` high at the same edge: reset wins.

## Structure
- Package `div_pkg` holds the state typedef (`typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t`).
- The counter width `$clog2(n)` is a localparam inside `div_seq`.
- Sub-module `div_step`, combinational, parameter n:
  - Inputs P, A, B; outputs P', A' for one restoring iteration.
  - It is instantiated once, and `div_seq` registers its outputs.
- `div_step` is independently testable against `mul`, which is expected to satisfy `mul(q,b)+r == a`.

## Test plan
- n=8, a=100, b=7, one-cycle `start` → `done` pulses once at E0+9, `q`=14, `r`=2, `dz`=0; `busy` high for 8 cycles.
- a=255, b=1 → `q`=255, `r`=0; a=5, b=9 → `q`=0, `r`=5; a=0, b=3 → `q`=0, `r`=0.
- a=42, b=0 → `done` in the cycle after E0, `q`=8'hFF, `r`=42, `dz`=1, `busy` never high.
- `start` pulsed with a=200, b=3 mid-RUN of 100/7 → ignored; the result remains 14 rem 2, and exactly one `done` pulse occurs.
- `rst` asserted at iteration 4 of 100/7 → next cycle all outputs 0, no `done`. A following request 9/2 → `q`=4, `r`=1.
- `start` held high with fixed a=77, b=5 for 30 cycles → `done` every 10 cycles, `q`=15, `r`=2 each time. Random sweep: check `q`*`b`+`r`==`a` and `r`<`b`.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration.
module div_step #(
    parameter int n = 8
) (
    input  logic [n-1:0] p,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] p_next,
    output logic [n-1:0] a_next
);
    logic [n:0] sh;
    logic       ge;
    // The remainder after restoring is always below b, so n bits hold it.
    always_comb begin
        sh     = {p, a[n-1]};
        ge     = sh >= {1'b0, b};
        p_next = ge ? n'(sh - {1'b0, b}) : sh[n-1:0];
        a_next = {a[n-2:0], ge};
    end
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential unsigned divider, one quotient bit per clock.
module div_seq #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] q,
    output logic [n-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dz
);
    import div_pkg::*;
    localparam int cw = $clog2(n);
    localparam logic [cw-1:0] last = cw'(n - 1);
    div_state_t state, state_d;
    logic [n-1:0] p_q, a_q, b_q, p_next, a_next;
    logic [cw-1:0] cnt;
    div_step #(.n(n)) u_step (
        .p(p_q), .a(a_q), .b(b_q), .p_next(p_next), .a_next(a_next)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    always_comb begin
        state_d = state == IDLE ? (start ? (b == '0 ? DONE : RUN) : IDLE)
                : state == RUN  ? (cnt == last ? DONE : RUN)
                : IDLE;
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
        end else if (state == IDLE && start) begin
            b_q <= b;
            if (b != '0) begin
                p_q <= '0;
                a_q <= a;
                cnt <= '0;
            end else begin
                q  <= '1;
                r  <= a;
                dz <= 1'b1;
            end
        end else if (state == RUN) begin
            p_q <= p_next;
            a_q <= a_next;
            cnt <= cnt + 1'b1;
            if (cnt == last) begin
                q  <= a_next;
                r  <= p_next;
                dz <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: vector table, corner sequences and random sweep for div_seq.
module tb_div_seq;
    localparam int n = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [n-1:0] a = '0, b = '0, q, r;
    logic busy, done, dz;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    div_seq #(.n(n)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
    );

    typedef struct {int a; int b; int q; int r; int dz; int lat; int bsy;} vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One request, then watch 12 cycles for latency, busy and done pulses.
    task automatic run_op(input int ai, input int bi, output int gq, output int gr,
                          output int gdz, output int lat, output int bcnt, output int dcnt);
        @(negedge clk);
        a = n'(ai); b = n'(bi); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        gq = -1; gr = -1; gdz = -1; lat = 0; bcnt = 0; dcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = k; gq = int'(q); gr = int'(r); gdz = int'(dz);
                end
            end
        end
    endtask

    initial begin
        int gq, gr, gdz, lat, bcnt, dcnt, last_k, ai, bi;
        vecs[0] = '{100, 7, 14, 2, 0, 9, 8};
        vecs[1] = '{255, 1, 255, 0, 0, 9, 8};
        vecs[2] = '{5, 9, 0, 5, 0, 9, 8};
        vecs[3] = '{0, 3, 0, 0, 0, 9, 8};
        vecs[4] = '{42, 0, 255, 42, 1, 1, 0};

        repeat (2) @(negedge clk);
        chk("reset_q", q, 0);
        chk("reset_r", r, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", dz, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, gq, gr, gdz, lat, bcnt, dcnt);
            chk($sformatf("vec%0d_q", i), gq, vecs[i].q);
            chk($sformatf("vec%0d_r", i), gr, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), gdz, vecs[i].dz);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].bsy);
            chk($sformatf("vec%0d_done_pulses", i), dcnt, 1);
        end

        // A start pulse during RUN must not disturb or queue anything.
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3) begin a = 8'd200; b = 8'd3; start = 1'b1; end
            else start = 1'b0;
            if (done) begin
                dcnt++;
                chk("ignore_q", q, 14);
                chk("ignore_r", r, 2);
            end
        end
        chk("ignore_done_pulses", dcnt, 1);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz", dz, 0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run_op(9, 2, gq, gr, gdz, lat, bcnt, dcnt);
        chk("after_abort_q", gq, 4);
        chk("after_abort_r", gr, 1);

        // Start held high re-issues every n+2 cycles.
        @(negedge clk);
        a = 8'd77; b = 8'd5; start = 1'b1;
        dcnt = 0; last_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("held_q", q, 15);
                chk("held_r", r, 2);
                if (last_k != 0) chk("held_interval", k - last_k, 10);
                last_k = k;
            end
        end
        chk("held_done_count", dcnt, 3);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Random sweep against plain integer division.
        for (int t = 0; t < 40; t++) begin
            ai = int'($urandom_range(0, 255));
            bi = (t % 8 == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(ai, bi, gq, gr, gdz, lat, bcnt, dcnt);
            chk($sformatf("rand%0d_q(%0d/%0d)", t, ai, bi), gq, bi == 0 ? 255 : ai / bi);
            chk($sformatf("rand%0d_r(%0d/%0d)", t, ai, bi), gr, bi == 0 ? ai : ai % bi);
            chk($sformatf("rand%0d_dz", t), gdz, bi == 0 ? 1 : 0);
            chk($sformatf("rand%0d_latency", t), lat, bi == 0 ? 1 : n + 1);
            if (bi != 0) begin
                chk($sformatf("rand%0d_qb_plus_r", t), gq * bi + gr, ai);
                chk($sformatf("rand%0d_r_lt_b", t), gr < bi, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
